hazard_track_unit: RTL and testbench

- Producer side of operand forwarding in the 5-stage pipeline.
- Tracks destination register, write-enable and load flag for every instruction as it moves ID/EX -> EX/MEM -> MEM/WB.
- Drives the EX/MEM and MEM/WB rd/wren signals that the forwarding selector consumes.
- Detects load-use hazards, inserts bubbles, honours branch flushes and data-memory freezes, and keeps a saturating stall-cycle counter for performance monitoring.

---
 rtl/hazard_track_unit.sv | 133 +++++++++++++
 tb/tb_hazard_track_unit.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_track_unit.sv
// rtl/hazard_track_unit.sv - destination tracking, load-use stall and flush/freeze control
module hazard_track_unit #(
    parameter int LOAD_USE_STALLS = 1,
    parameter int CNT_W           = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [4:0]       ID_rs1_i,
    input  logic [4:0]       ID_rs2_i,
    input  logic             ID_rs1_use_i,
    input  logic             ID_rs2_use_i,
    input  logic [4:0]       ID_rd_i,
    input  logic             ID_rd_wren_i,
    input  logic             ID_is_load_i,
    input  logic             flush_i,
    input  logic             dmem_busy_i,
    output logic             stall_o,
    output logic             freeze_o,
    output logic [4:0]       IDEX_rd_o,
    output logic             IDEX_rd_wren_o,
    output logic [4:0]       EXMEM_rd_o,
    output logic             EXMEM_rd_wren_o,
    output logic [4:0]       MEMWB_rd_o,
    output logic             MEMWB_rd_wren_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    logic [4:0]       idex_rd_q, idex_rd_d;
    logic             idex_wren_q, idex_wren_d;
    logic             idex_ld_q, idex_ld_d;
    logic [4:0]       exmem_rd_q, exmem_rd_d;
    logic             exmem_wren_q, exmem_wren_d;
    logic             exmem_ld_q, exmem_ld_d;
    logic [4:0]       memwb_rd_q, memwb_rd_d;
    logic             memwb_wren_q, memwb_wren_d;
    logic             pending_flush_q, pending_flush_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic dep_idex, dep_exmem, load_use, kill;

    // True when a load in the given stage writes a register the ID instruction reads
    function automatic logic dep_on(input logic ld, input logic wren, input logic [4:0] rd,
                                    input logic [4:0] rs1, input logic rs1_use,
                                    input logic [4:0] rs2, input logic rs2_use);
        return ld && wren && ((rs1_use && (rs1 == rd)) || (rs2_use && (rs2 == rd)));
    endfunction

    // Hazard detection and stall/freeze outputs; freeze outranks flush, flush outranks stall
    always_comb begin
        dep_idex  = dep_on(idex_ld_q, idex_wren_q, idex_rd_q,
                           ID_rs1_i, ID_rs1_use_i, ID_rs2_i, ID_rs2_use_i);
        dep_exmem = dep_on(exmem_ld_q, exmem_wren_q, exmem_rd_q,
                           ID_rs1_i, ID_rs1_use_i, ID_rs2_i, ID_rs2_use_i);
        load_use  = (LOAD_USE_STALLS == 2) ? (dep_idex || dep_exmem) : dep_idex;
        kill      = flush_i || pending_flush_q;
        freeze_o  = dmem_busy_i;
        stall_o   = load_use && !kill && !dmem_busy_i;
    end

    // Next-state: hold everything while frozen (remembering flushes), else advance
    always_comb begin
        idex_rd_d       = idex_rd_q;
        idex_wren_d     = idex_wren_q;
        idex_ld_d       = idex_ld_q;
        exmem_rd_d      = exmem_rd_q;
        exmem_wren_d    = exmem_wren_q;
        exmem_ld_d      = exmem_ld_q;
        memwb_rd_d      = memwb_rd_q;
        memwb_wren_d    = memwb_wren_q;
        pending_flush_d = pending_flush_q;
        stall_cnt_d     = stall_cnt_q;
        if (dmem_busy_i) begin
            if (flush_i) begin
                pending_flush_d = 1'b1;
            end
        end else begin
            memwb_rd_d      = exmem_rd_q;
            memwb_wren_d    = exmem_wren_q;
            exmem_rd_d      = idex_rd_q;
            exmem_wren_d    = idex_wren_q;
            exmem_ld_d      = idex_ld_q;
            pending_flush_d = 1'b0;
            if (kill || load_use) begin
                idex_rd_d   = 5'd0;
                idex_wren_d = 1'b0;
                idex_ld_d   = 1'b0;
            end else begin
                idex_rd_d   = ID_rd_i;
                idex_wren_d = ID_rd_wren_i && (ID_rd_i != 5'd0);
                idex_ld_d   = ID_is_load_i;
            end
        end
        if (stall_o && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            idex_rd_q       <= 5'd0;
            idex_wren_q     <= 1'b0;
            idex_ld_q       <= 1'b0;
            exmem_rd_q      <= 5'd0;
            exmem_wren_q    <= 1'b0;
            exmem_ld_q      <= 1'b0;
            memwb_rd_q      <= 5'd0;
            memwb_wren_q    <= 1'b0;
            pending_flush_q <= 1'b0;
            stall_cnt_q     <= '0;
        end else begin
            idex_rd_q       <= idex_rd_d;
            idex_wren_q     <= idex_wren_d;
            idex_ld_q       <= idex_ld_d;
            exmem_rd_q      <= exmem_rd_d;
            exmem_wren_q    <= exmem_wren_d;
            exmem_ld_q      <= exmem_ld_d;
            memwb_rd_q      <= memwb_rd_d;
            memwb_wren_q    <= memwb_wren_d;
            pending_flush_q <= pending_flush_d;
            stall_cnt_q     <= stall_cnt_d;
        end
    end

    assign IDEX_rd_o       = idex_rd_q;
    assign IDEX_rd_wren_o  = idex_wren_q;
    assign EXMEM_rd_o      = exmem_rd_q;
    assign EXMEM_rd_wren_o = exmem_wren_q;
    assign MEMWB_rd_o      = memwb_rd_q;
    assign MEMWB_rd_wren_o = memwb_wren_q;
    assign stall_cnt_o     = stall_cnt_q;

endmodule

// File: tb/tb_hazard_track_unit.sv
// tb/tb_hazard_track_unit.sv - model-checked bench for hazard_track_unit
module tb_hazard_track_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] rs1, rs2, rd;
    logic       u1, u2, wren, ld, flush, busy;

    logic       st [2];
    logic       fr [2];
    logic [4:0] r0 [2];
    logic       w0 [2];
    logic [4:0] r1 [2];
    logic       w1 [2];
    logic [4:0] r2 [2];
    logic       w2 [2];
    logic [3:0]  cnt_a;
    logic [15:0] cnt_b;
    logic [15:0] cnt [2];

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_on = 1'b0;

    always #5 clk = ~clk;

    // instance 0: one bubble, 4-bit counter; instance 1: two bubbles, 16-bit counter
    hazard_track_unit #(.LOAD_USE_STALLS(1), .CNT_W(4)) dut_a (
        .clk_i(clk), .rst_ni(rst_n),
        .ID_rs1_i(rs1), .ID_rs2_i(rs2), .ID_rs1_use_i(u1), .ID_rs2_use_i(u2),
        .ID_rd_i(rd), .ID_rd_wren_i(wren), .ID_is_load_i(ld),
        .flush_i(flush), .dmem_busy_i(busy),
        .stall_o(st[0]), .freeze_o(fr[0]),
        .IDEX_rd_o(r0[0]), .IDEX_rd_wren_o(w0[0]),
        .EXMEM_rd_o(r1[0]), .EXMEM_rd_wren_o(w1[0]),
        .MEMWB_rd_o(r2[0]), .MEMWB_rd_wren_o(w2[0]),
        .stall_cnt_o(cnt_a));

    hazard_track_unit #(.LOAD_USE_STALLS(2), .CNT_W(16)) dut_b (
        .clk_i(clk), .rst_ni(rst_n),
        .ID_rs1_i(rs1), .ID_rs2_i(rs2), .ID_rs1_use_i(u1), .ID_rs2_use_i(u2),
        .ID_rd_i(rd), .ID_rd_wren_i(wren), .ID_is_load_i(ld),
        .flush_i(flush), .dmem_busy_i(busy),
        .stall_o(st[1]), .freeze_o(fr[1]),
        .IDEX_rd_o(r0[1]), .IDEX_rd_wren_o(w0[1]),
        .EXMEM_rd_o(r1[1]), .EXMEM_rd_wren_o(w1[1]),
        .MEMWB_rd_o(r2[1]), .MEMWB_rd_wren_o(w2[1]),
        .stall_cnt_o(cnt_b));

    assign cnt[0] = {12'd0, cnt_a};
    assign cnt[1] = cnt_b;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: per instance, a 3-entry list of in-flight writers (0=IDEX,1=EXMEM,2=MEMWB)
    typedef struct {
        int rd;
        bit wr;
        bit ld;
    } slot_t;

    slot_t m_pipe [2][3];
    bit    m_pend [2];
    int    m_cnt  [2];
    int    m_lus  [2] = '{1, 2};
    int    m_max  [2] = '{15, 65535};

    function automatic bit reads(input int r);
        return (u1 && int'(rs1) == r) || (u2 && int'(rs2) == r);
    endfunction

    function automatic bit model_stall(input int i);
        bit hz = 1'b0;
        for (int s = 0; s < m_lus[i]; s++)
            if (m_pipe[i][s].ld && m_pipe[i][s].wr && reads(m_pipe[i][s].rd)) hz = 1'b1;
        return hz;
    endfunction

    // Compare on the falling edge, then advance the model to what the next rising edge produces
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            bit hz, kl, es;
            slot_t nw;
            hz = model_stall(i);
            kl = flush || m_pend[i];
            es = hz && !kl && !busy;
            if (chk_on) begin
                chk($sformatf("stall[%0d]", i), int'(st[i]), int'(es));
                chk($sformatf("freeze[%0d]", i), int'(fr[i]), int'(busy));
                chk($sformatf("idex_rd[%0d]", i), int'(r0[i]), m_pipe[i][0].rd);
                chk($sformatf("idex_wr[%0d]", i), int'(w0[i]), int'(m_pipe[i][0].wr));
                chk($sformatf("exmem_rd[%0d]", i), int'(r1[i]), m_pipe[i][1].rd);
                chk($sformatf("exmem_wr[%0d]", i), int'(w1[i]), int'(m_pipe[i][1].wr));
                chk($sformatf("memwb_rd[%0d]", i), int'(r2[i]), m_pipe[i][2].rd);
                chk($sformatf("memwb_wr[%0d]", i), int'(w2[i]), int'(m_pipe[i][2].wr));
                chk($sformatf("cnt[%0d]", i), int'(cnt[i]), m_cnt[i]);
            end
            if (!rst_n) begin
                for (int s = 0; s < 3; s++) m_pipe[i][s] = '{0, 1'b0, 1'b0};
                m_pend[i] = 1'b0;
                m_cnt[i]  = 0;
            end else begin
                if (es && m_cnt[i] < m_max[i]) m_cnt[i]++;
                if (busy) begin
                    if (flush) m_pend[i] = 1'b1;
                end else begin
                    if (kl || hz) nw = '{0, 1'b0, 1'b0};
                    else          nw = '{int'(rd), wren && rd != 0, ld};
                    m_pipe[i][2] = m_pipe[i][1];
                    m_pipe[i][2].ld = 1'b0;
                    m_pipe[i][1] = m_pipe[i][0];
                    m_pipe[i][0] = nw;
                    m_pend[i] = 1'b0;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic instr(input int d, input bit w, input bit l,
                         input int a, input bit ua, input int b, input bit ub);
        rd = d[4:0]; wren = w; ld = l;
        rs1 = a[4:0]; u1 = ua; rs2 = b[4:0]; u2 = ub;
        #1;
    endtask

    task automatic nop();
        instr(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; flush = 1'b0; busy = 1'b0;
        nop();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; busy = 1'b0;
        nop();
        do_reset();
        chk_on = 1'b1;
        chk("reset_stall", int'(st[0]), 0);
        chk("reset_cnt", int'(cnt_b), 0);

        // plain ALU stream: rd advances one stage per edge
        instr(5, 1, 0, 1, 1, 2, 1); step();
        instr(6, 1, 0, 1, 1, 2, 1); step();
        chk("alu_exmem5", int'(r1[1]), 5);
        instr(7, 1, 0, 1, 1, 2, 1); step();
        chk("alu_memwb5", int'(r2[1]), 5);
        chk("alu_exmem6", int'(r1[0]), 6);
        nop(); step(); step();
        chk("alu_cnt", int'(cnt_b), 0);

        // LW x5 then ADD x6,x5,x1
        do_reset();
        instr(5, 1, 1, 0, 1, 0, 0); step();
        instr(6, 1, 0, 5, 1, 1, 1);
        chk("lu_stall_a0", int'(st[0]), 1);
        chk("lu_stall_b0", int'(st[1]), 1);
        step();
        chk("lu_a_exmem_ld", int'(r1[0]), 5);
        chk("lu_stall_a1", int'(st[0]), 0);
        chk("lu_stall_b1", int'(st[1]), 1);
        step();
        chk("lu_a_bubble", int'(w1[0]), 0);
        chk("lu_stall_b2", int'(st[1]), 0);
        nop(); step();
        chk("lu_cnt_a", int'(cnt_a), 1);
        chk("lu_cnt_b", int'(cnt_b), 2);

        // LW x0 and an x0 consumer: never tracked, never stalls
        do_reset();
        instr(0, 1, 1, 0, 0, 0, 0); step();
        chk("x0_idex_wr", int'(w0[0]), 0);
        instr(3, 1, 0, 0, 1, 0, 1);
        chk("x0_stall_a", int'(st[0]), 0);
        chk("x0_stall_b", int'(st[1]), 0);
        step();
        chk("x0_exmem_wr", int'(w1[1]), 0);

        // freeze for 3 cycles with a flush in the middle one
        do_reset();
        instr(9, 1, 0, 0, 0, 0, 0); step();
        instr(10, 1, 0, 0, 0, 0, 0);
        busy = 1'b1; #1;
        chk("frz_1", int'(fr[0]), 1);
        step();
        flush = 1'b1; #1;
        chk("frz_2", int'(fr[1]), 1);
        chk("frz_hold2", int'(r0[0]), 9);
        step();
        flush = 1'b0; #1;
        chk("frz_3", int'(fr[0]), 1);
        step();
        chk("frz_hold3", int'(r0[1]), 9);
        busy = 1'b0; #1;
        chk("frz_off", int'(fr[0]), 0);
        step();
        chk("frz_killed", int'(w0[0]), 0);
        chk("frz_exmem9", int'(r1[0]), 9);

        // saturation: self-dependent loads keep re-triggering the hazard
        do_reset();
        instr(5, 1, 1, 5, 1, 0, 0);
        for (int k = 0; k < 40; k++) step();
        chk("sat_cnt_a", int'(cnt_a), 15);
        rst_n = 1'b0; step(); rst_n = 1'b1;
        nop();
        chk("rst_cnt_a", int'(cnt_a), 0);
        chk("rst_cnt_b", int'(cnt_b), 0);
        chk("rst_idex_a", int'(r0[0]), 0);
        chk("rst_exmem_b", int'(w1[1]), 0);

        // randomized traffic with small register indices to provoke hazards
        for (int k = 0; k < 1500; k++) begin
            rst_n = ($urandom_range(0, 63) != 0);
            busy  = ($urandom_range(0, 6) == 0);
            flush = ($urandom_range(0, 9) == 0);
            instr($urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 2) != 0,
                  $urandom_range(0, 3), $urandom_range(0, 1),
                  $urandom_range(0, 3), $urandom_range(0, 1));
            step();
        end
        rst_n = 1'b1; busy = 1'b0; flush = 1'b0;
        nop(); step(); step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
